// File: rtl/mul_feed_421.sv
// Sequential shift-add multiplier for mod-421 operands with a single conditional fold
// so the product fits the 17-bit Barrett input. Optional operand range flag: MUL_FEED_421_RANGE_CHECK_EN.
module mul_feed_421 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [8:0]  in_a,
   input  logic [8:0]  in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [16:0] out_p,
   output logic        err
);

   localparam int unsigned OP_W  = 9;
   localparam int unsigned ACC_W = 18;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned P_W   = 17;

   localparam logic [ACC_W-1:0] FOLD_LIM = 18'd131072;
   localparam logic [ACC_W-1:0] FOLD_K   = 18'd107776;
   localparam logic [CNT_W-1:0] LAST_BIT = 4'd8;

   typedef enum logic [1:0] {IDLE, BUSY, FOLD, DONE} state_t;

   state_t            state_q, state_d;
   logic [OP_W-1:0]   a_q, a_d;
   logic [OP_W-1:0]   b_q, b_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [P_W-1:0]    p_q, p_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
`ifdef MUL_FEED_421_RANGE_CHECK_EN
   logic              err_q, err_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         p_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
`ifdef MUL_FEED_421_RANGE_CHECK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         p_q         <= p_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
`ifdef MUL_FEED_421_RANGE_CHECK_EN
         err_q       <= err_d;
`endif
      end
   end

   // Next-state, shift-add step and fold
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
`ifdef MUL_FEED_421_RANGE_CHECK_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = BUSY;
`ifdef MUL_FEED_421_RANGE_CHECK_EN
               err_d   = (in_a >= 9'd421) || (in_b >= 9'd421);
`endif
            end
         end
         BUSY: begin
            if (b_q[cnt_q]) begin
               acc_d = acc_q + (ACC_W'(a_q) << cnt_q);
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == LAST_BIT) begin
               state_d = FOLD;
            end
         end
         FOLD: begin
            // 107776 = 421*256, so subtracting it preserves the residue
            p_d     = (acc_q >= FOLD_LIM) ? P_W'(acc_q - FOLD_K) : P_W'(acc_q);
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
`ifdef MUL_FEED_421_RANGE_CHECK_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_p     = p_q;
`ifdef MUL_FEED_421_RANGE_CHECK_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_mul_feed_421.sv
// Scoreboard bench for mul_feed_421: expected folded products are queued at acceptance
// and compared when the DUT completes a handshake on the output side.
module tb_mul_feed_421;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [8:0]  in_a;
   logic [8:0]  in_b;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] out_p;
   logic        err;

   typedef struct {
      int unsigned p;
      int unsigned res;
      bit          e;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0;
   int          n_err = 0;
   int          cyc   = 0;
   int          acc_cyc;
   int          lat;
   int          t0;
   int          k;
   logic [16:0] held_p;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_feed_421 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_p     (out_p),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input int unsigned a, input int unsigned b);
      exp_t e;
      int unsigned prod;
      prod  = a * b;
      e.res = prod % 421;
      e.p   = (prod >= 131072) ? prod - 107776 : prod;
`ifdef MUL_FEED_421_RANGE_CHECK_EN
      e.e   = (a >= 421) || (b >= 421);
`else
      e.e   = 1'b0;
`endif
      return e;
   endfunction

   // Output monitor: every completed output handshake pops one expectation
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("out_p", 32'(out_p), 32'(e.p));
            check("out_p_mod421", 32'(out_p) % 421, 32'(e.res));
            check("err", 32'(err), 32'(e.e));
         end
      end
   end

   // Drive one operand pair; returns on the negedge after the accepting edge
   task automatic send(input int unsigned a, input int unsigned b);
      int w;
      w = 0;
      while (!in_ready && w < 60) begin
         @(negedge clk);
         w++;
      end
      check("in_ready_timeout", 32'(w < 60), 32'd1);
      in_valid = 1'b1;
      in_a     = 9'(a);
      in_b     = 9'(b);
      @(posedge clk);
      acc_cyc  = cyc;
      sb.push_back(model(a, b));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("out_valid_timeout", 32'(n < 40), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_p", 32'(out_p), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;

      // Max operands, accepted on the first edge after release
      send(420, 420);
      check("first_accept_cycle_after_release", 32'(in_ready), 32'd0);
      wait_valid(lat);
      check("latency_max_11", 32'(lat >= 10 && lat <= 11), 32'd1);
      check("max_out_p_direct", 32'(out_p), 32'd68624);
      @(negedge clk);
      check("valid_one_cycle", 32'(out_valid), 32'd0);
      check("ready_after_done", 32'(in_ready), 32'd1);

      // Back-to-back throughput with out_ready held high
      send(255, 3);
      t0 = acc_cyc;
      send(0, 5);
      check("throughput_12", 32'(acc_cyc - t0), 32'd12);
      send(300, 0);
      send(400, 330);
      send(0, 0);
      for (int i = 0; i < 4; i++) begin
         send($urandom_range(0, 420), $urandom_range(0, 420));
      end
      wait_valid(lat);
      @(negedge clk);

      // Backpressure: hold DONE with stray in_valid pulses
      out_ready = 1'b0;
      send(17, 19);
      wait_valid(lat);
      held_p = out_p;
      check("hold_p_value", 32'(held_p), 32'd323);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a     = 9'(i + 1);
         in_b     = 9'd1;
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'd1);
         check("hold_out_p", 32'(out_p), 32'(held_p));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("hold_release_ready", 32'(in_ready), 32'd1);
      check("hold_queue_empty", 32'(sb.size()), 32'd0);

      // Asynchronous reset in BUSY discards the transaction
      send(100, 100);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_p", 32'(out_p), 32'd0);
      check("async_rst_in_ready", 32'(in_ready), 32'd1);
      check("async_rst_out_valid", 32'(out_valid), 32'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) k++;
      end
      check("no_valid_after_reset", 32'(k), 32'd0);
      send(7, 9);
      wait_valid(lat);
      @(negedge clk);

      // Out-of-range operand: computation unchanged, err reflects build option
      send(500, 2);
      wait_valid(lat);
      @(negedge clk);
      @(negedge clk);
      check("err_cleared_idle", 32'(err), 32'd0);

      k = 0;
      while (sb.size() != 0 && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
